// File: rtl/bp_io_cmd_arbiter.sv
// Shares one host-side BedRock I/O command/response port among several requesters:
// round-robin command grant, credit-limited issue, in-order response steering, quiesce FSM.
module bp_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p*msg_width_p-1:0]       req_cmd_i,
    input  logic [num_req_p-1:0]                   req_cmd_v_i,
    output logic [num_req_p-1:0]                   req_cmd_yumi_o,
    output logic [msg_width_p-1:0]                 req_resp_o,
    output logic [num_req_p-1:0]                   req_resp_v_o,
    input  logic [num_req_p-1:0]                   req_resp_yumi_i,
    output logic [msg_width_p-1:0]                 mem_cmd_o,
    output logic                                   mem_cmd_v_o,
    input  logic                                   mem_cmd_ready_i,
    input  logic [msg_width_p-1:0]                 mem_resp_i,
    input  logic                                   mem_resp_v_i,
    output logic                                   mem_resp_yumi_o,
    input  logic                                   quiesce_i,
    output logic                                   halted_o,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o
);

    localparam int IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int CntW = $clog2(max_outstanding_p + 1);

    localparam logic [CntW-1:0] MaxCnt  = CntW'(max_outstanding_p);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(max_outstanding_p - 1);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StHalt  = 2'd2;

    logic [IdW-1:0]  rrPtr_q, rrPtr_d;
    logic [IdW-1:0]  winner;
    logic [IdW-1:0]  head;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [1:0]      state_q, state_d;
    logic [IdW-1:0]  idFifo_q [max_outstanding_p];

    logic anyValid;
    logic fifoFull;
    logic fifoEmpty;
    logic issueOk;
    logic cmdXfer;
    logic respPop;
    int   idx;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    // The outstanding count equals the ID FIFO occupancy, so it also serves as the FIFO level.
    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == MaxCnt);
    assign issueOk   = (state_q == StRun) && (count_q < MaxCnt) && !fifoFull;

    always_comb begin
        winner   = '0;
        anyValid = 1'b0;
        idx      = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!anyValid && req_cmd_v_i[IdW'(idx)]) begin
                winner   = IdW'(idx);
                anyValid = 1'b1;
            end
        end
    end

    assign mem_cmd_v_o = reset_n_i & issueOk & anyValid;
    assign cmdXfer     = mem_cmd_v_o & mem_cmd_ready_i;
    assign mem_cmd_o   = req_cmd_i[int'(winner)*msg_width_p +: msg_width_p];

    always_comb begin
        req_cmd_yumi_o = '0;
        if (cmdXfer) begin
            req_cmd_yumi_o[winner] = 1'b1;
        end
    end

    assign head       = idFifo_q[rdPtr_q];
    assign req_resp_o = mem_resp_i;

    always_comb begin
        req_resp_v_o = '0;
        if (reset_n_i && mem_resp_v_i && !fifoEmpty) begin
            req_resp_v_o[head] = 1'b1;
        end
    end

    // A response arriving with nothing outstanding is consumed and dropped.
    assign respPop         = reset_n_i & mem_resp_v_i & !fifoEmpty & req_resp_yumi_i[head];
    assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & (fifoEmpty | req_resp_yumi_i[head]);

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (cmdXfer) begin
            rrPtr_d = (int'(winner) + 1 >= num_req_p) ? '0 : winner + IdW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({cmdXfer, respPop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    assign wrPtr_d = cmdXfer ? nextPtr(wrPtr_q) : wrPtr_q;
    assign rdPtr_d = respPop ? nextPtr(rdPtr_q) : rdPtr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (quiesce_i) state_d = StDrain;
            end
            StDrain: begin
                if (!quiesce_i)          state_d = StRun;
                else if (count_d == '0)  state_d = StHalt;
            end
            StHalt: begin
                if (!quiesce_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rrPtr_q <= '0;
            count_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            state_q <= StRun;
        end else begin
            rrPtr_q <= rrPtr_d;
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmdXfer) begin
            idFifo_q[wrPtr_q] <= winner;
        end
    end

    assign halted_o      = (state_q == StHalt);
    assign outstanding_o = count_q;

    spuriousResp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   !(mem_resp_v_i && fifoEmpty));

endmodule
